adder_subtractor_4bit: RTL and testbench
========================================

Name: adder_subtractor_4bit

Overview:
- Registered two's-complement adder/subtractor, WIDTH bits (default 4), with ripple-carry datapath.
- Mode input selects add (0) or subtract (1); subtraction computes a + ~b + 1.
- Results are registered with one-cycle latency, plus carry, signed-overflow and zero flags.
- Used as a small ALU arithmetic slice inside the datapath.

Parameters:
- WIDTH, 4, operand/result width in bits (legal ≥ 2).

Ports:
- clk  in  1  rising-edge clock, sole clock domain.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- cin  in  1  mode: 0 = add (a+b), 1 = subtract (a-b).
- in_valid  in  1  operands/mode valid this cycle.
- s  out  WIDTH  registered sum/difference, low WIDTH bits.
- cout  out  1  registered carry out of MSB; in subtract mode 1 = no borrow (a ≥ b unsigned).
- ovf  out  1  registered signed overflow.
- zero  out  1  registered, 1 when s == 0.
- out_valid  out  1  registered copy of in_valid.

Behaviour:
- Combinational core:
  - bx = b XOR {WIDTH{cin}}.
  - {c_final, r} = a + bx + cin, built as a ripple chain of WIDTH full adders.
  - Carry into bit 0 = cin.
- Flags:
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = (r == 0).
- Registers: on rising clk with rst_n = 0, s, cout, ovf, zero and out_valid all clear to 0. The zero flag is therefore also 0 in reset, not 1.
- Capture: on rising clk with rst_n = 1 and in_valid = 1, capture s = r, cout = c_final, ovf, zero, and set out_valid = 1.
- Hold: with rst_n = 1 and in_valid = 0, hold s/cout/ovf/zero at their previous values and clear out_valid to 0.
- Latency: exactly 1 cycle from sampled inputs to outputs.
- Throughput: one operation per cycle; back-to-back in_valid is allowed. No backpressure.
- Wrap-around:
  - Results are modulo 2^WIDTH; the carry/borrow is reported only through cout.
  - Example: 4'b1111 + 4'b0001 gives s = 0000, cout = 1, ovf = 0, zero = 1.
- Reset priority: reset asserted together with in_valid wins; outputs clear and out_valid = 0.
- Reset mid-stream: the in-flight result is discarded.
- Signed limit: -8 - 1 (a = 1000, b = 0001, cin = 1) gives s = 0111, cout = 1, ovf = 1.
- No latches; all outputs come straight from flops.

Decomposition:
- Package adder_subtractor_pkg: WIDTH default constant; MODE_ADD = 1'b0, MODE_SUB = 1'b1.
- Sub-module full_adder (a, b, ci → s, co), instantiated WIDTH times via generate.
- Top level holds the XOR inversion, flag logic and output registers.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with in_valid = 1 and a = b = 4'b1011 → s = 0, cout = 0, ovf = 0, zero = 0, out_valid = 0.
- Add with carry: a = 1011, b = 1011, cin = 0, in_valid = 1 → next cycle s = 0110, cout = 1, ovf = 1, zero = 0, out_valid = 1.
- Subtract equal: a = 1010, b = 1010, cin = 1 → s = 0000, cout = 1 (no borrow), ovf = 0, zero = 1.
- Add overflow and borrow:
  - a = 1011, b = 1111, cin = 0 → s = 1010, cout = 1, ovf = 0.
  - Then a = 0011, b = 0101, cin = 1 → s = 1110, cout = 0 (borrow), ovf = 0.
- Zero and hold: a = 0000, b = 0000, cin = 0 → s = 0000, cout = 0, zero = 1. Then drop in_valid with changed operands → outputs hold, out_valid = 0.
- Exhaustive/random: all 2^(2·WIDTH+1) combinations, back-to-back with random in_valid, checked 1 cycle later against a + (cin ? -b : b) reference model for s, cout, ovf, zero. Include reset pulse mid-stream.

Source files
------------

// File: rtl/adder_subtractor_pkg.sv
// Shared constants for the registered adder/subtractor slice.
package adder_subtractor_pkg;

    // Default operand/result width.
    localparam int WIDTH_DEFAULT = 4;

    // Encoding of the cin/mode input.
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage : adder_subtractor_pkg

// File: rtl/adder_subtractor_4bit_full_adder.sv
// One-bit full adder cell, the unit of the ripple-carry chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule : full_adder

// File: rtl/adder_subtractor_4bit.sv
// Registered two's-complement adder/subtractor with carry, overflow and
// zero flags. Subtraction is a + ~b + 1: b is inverted and the mode bit
// doubles as the carry into bit 0.
module adder_subtractor_4bit
    import adder_subtractor_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             out_valid
);

    logic             sub_mode;
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] r;
    logic [WIDTH:0]   carry;
    logic             c_final;
    logic             ovf_comb;
    logic             zero_comb;

    assign sub_mode = (cin == MODE_SUB);
    assign bx       = b ^ {WIDTH{sub_mode}};
    assign carry[0] = sub_mode;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_ripple
            full_adder u_fa (
                .a  (a[i]),
                .b  (bx[i]),
                .ci (carry[i]),
                .s  (r[i]),
                .co (carry[i+1])
            );
        end
    endgenerate

    // Signed overflow shows up as disagreement between carry into and out of the MSB.
    assign c_final   = carry[WIDTH];
    assign ovf_comb  = carry[WIDTH-1] ^ carry[WIDTH];
    assign zero_comb = (r == '0);

    // Output registers: sync clear, capture on in_valid, otherwise hold results and drop out_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s         <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            s         <= r;
            cout      <= c_final;
            ovf       <= ovf_comb;
            zero      <= zero_comb;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule : adder_subtractor_4bit

// File: tb/tb_adder_subtractor_4bit.sv
// Self-checking bench for adder_subtractor_4bit: an expected-result queue
// is filled as each cycle's stimulus is driven and drained after the edge.
module tb_adder_subtractor_4bit;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
        logic         zero;
        logic         valid;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         in_valid;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         out_valid;

    int   passed = 0;
    int   total  = 0;
    res_t sb[$];
    res_t held = '0;
    res_t exp_r;
    res_t obs;

    adder_subtractor_4bit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    assign obs = {s, cout, ovf, zero, out_valid};

    // Reference arithmetic done with plain integers, independent of the carry chain.
    function automatic res_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic cv);
        res_t m;
        int ua, ub, sa, sb_i, ur, sr, lim;
        lim  = 1 << W;
        ua   = int'(av);
        ub   = int'(bv);
        sa   = (ua >= lim / 2) ? ua - lim : ua;
        sb_i = (ub >= lim / 2) ? ub - lim : ub;
        ur   = cv ? ua - ub : ua + ub;
        sr   = cv ? sa - sb_i : sa + sb_i;
        m.s     = ur[W-1:0];
        m.cout  = cv ? (ua >= ub) : (ur >= lim);
        m.ovf   = (sr < -(lim / 2)) || (sr > (lim / 2) - 1);
        m.zero  = (m.s == '0);
        m.valid = 1'b1;
        return m;
    endfunction

    // Drives one cycle of stimulus, queues the expected registered result, and steps past the edge.
    task automatic apply(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                         input logic v, input logic rn);
        res_t e;
        @(negedge clk);
        a        = av;
        b        = bv;
        cin      = cv;
        in_valid = v;
        rst_n    = rn;
        if (!rn) begin
            e = '0;
            held = '0;
        end else if (v) begin
            e = model(av, bv, cv);
            held = e;
        end else begin
            e = held;
            e.valid = 1'b0;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            apply(4'b1011, 4'b1011, 1'b0, 1'b1, 1'b0);
            exp_r = sb.pop_front();
            total++;
            if (obs !== exp_r)
                $display("FAIL reset[%0d]: got %b required %b", i, obs, exp_r);
            else
                passed++;
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] av[6] = '{4'b1011, 4'b1010, 4'b1011, 4'b0011, 4'b0000, 4'b1000};
        logic [W-1:0] bv[6] = '{4'b1011, 4'b1010, 4'b1111, 4'b0101, 4'b0000, 4'b0001};
        logic         cv[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        res_t         fixed[6];
        // Hand-derived results, checked in addition to the queued model values.
        fixed[0] = '{4'b0110, 1'b1, 1'b1, 1'b0, 1'b1};
        fixed[1] = '{4'b0000, 1'b1, 1'b0, 1'b1, 1'b1};
        fixed[2] = '{4'b1010, 1'b1, 1'b0, 1'b0, 1'b1};
        fixed[3] = '{4'b1110, 1'b0, 1'b0, 1'b0, 1'b1};
        fixed[4] = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b1};
        fixed[5] = '{4'b0111, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            apply(av[i], bv[i], cv[i], 1'b1, 1'b1);
            exp_r = sb.pop_front();
            total++;
            if (obs !== fixed[i] || obs !== exp_r)
                $display("FAIL directed[%0d]: got %b required %b", i, obs, fixed[i]);
            else
                passed++;
        end
    endtask

    task automatic test_hold();
        apply(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1);
        exp_r = sb.pop_front();
        total++;
        if (obs !== 8'b0000_0011)
            $display("FAIL hold_load: got %b required %b", obs, 8'b0000_0011);
        else
            passed++;
        for (int i = 0; i < 2; i++) begin
            apply(4'b0111, 4'b0110, 1'(i), 1'b0, 1'b1);
            exp_r = sb.pop_front();
            total++;
            if (obs !== 8'b0000_0010)
                $display("FAIL hold[%0d]: got %b required %b", i, obs, 8'b0000_0010);
            else
                passed++;
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        for (int k = 0; k < (1 << (2 * W + 1)); k++) begin
            logic [2*W:0] kv;
            logic         rn;
            kv = (2 * W + 1)'(k);
            rn = !(k == 200 || k == 201);
            apply(kv[W-1:0], kv[2*W-1:W], kv[2*W], ($urandom_range(0, 3) != 0) || k < 64, rn);
            exp_r = sb.pop_front();
            total++;
            if (obs !== exp_r) begin
                if (n < 10)
                    $display("FAIL stream[%0d]: got %b required %b", k, obs, exp_r);
                n++;
            end else begin
                passed++;
            end
        end
        // Sweep every operand/mode combination with in_valid held high.
        for (int k = 0; k < (1 << (2 * W + 1)); k++) begin
            logic [2*W:0] kv;
            kv = (2 * W + 1)'(k);
            apply(kv[W-1:0], kv[2*W-1:W], kv[2*W], 1'b1, 1'b1);
            exp_r = sb.pop_front();
            total++;
            if (obs !== exp_r) begin
                if (n < 10)
                    $display("FAIL exhaustive[%0d]: got %b required %b", k, obs, exp_r);
                n++;
            end else begin
                passed++;
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        in_valid = 1'b0;
        test_reset();
        test_directed();
        test_hold();
        test_back_to_back();
        total++;
        if (sb.size() != 0)
            $display("FAIL scoreboard_drain: got %0d entries required 0", sb.size());
        else
            passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_adder_subtractor_4bit
